// File: rtl/nios2_cpu_debug_pkg.sv
// Shared definitions for the Nios II debug monitor access block: controller
// states, jdo field positions and the default protected-region base.
package nios2_cpu_debug_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    J_RD   = 3'd1,
    J_CAP  = 3'd2,
    C_RD   = 3'd3,
    C_DONE = 3'd4
  } mon_state_e;

  localparam int JDO_W         = 38;
  localparam int DATA_W        = 32;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_DATA_LSB  = 3;
  localparam int JDO_CLR_READY = 34;
  localparam int JDO_CLR_ERROR = 35;

  localparam int unsigned PROT_BASE_DEFAULT = 32'h0000_00F0;

endpackage

// File: rtl/nios2_cpu_debug_mon_ram.sv
// Single-port monitor RAM: synchronous read with one cycle of latency,
// read-before-write, four byte-lane write enables.
module nios2_cpu_debug_mon_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem [DEPTH];

  // NOTE: the array and its read register carry no reset; clearing a RAM
  // costs a full sweep of writes and prevents mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/nios2_cpu_debug_mon_access.sv
// Arbitrates the debug monitor RAM between JTAG commands (address load,
// write, read) and the CPU slave port; JTAG work always takes priority.
module nios2_cpu_debug_mon_access
  import nios2_cpu_debug_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned PROT_BASE = PROT_BASE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic              debugaccess,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam logic [ADDR_W-1:0] PROT_ADDR = ADDR_W'(PROT_BASE);

  mon_state_e        state;
  logic [ADDR_W-1:0] mon_a_reg;
  logic              pend_wr;
  logic              pend_rd;
  logic [31:0]       pend_wr_data;

  logic [ADDR_W-1:0] jdo_addr;
  logic [31:0]       jdo_data;
  logic              unused_jdo;

  assign jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_data   = jdo[JDO_DATA_LSB +: DATA_W];
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_CLR_ERROR+1], jdo[JDO_DATA_LSB-1:0]};

  // A pulse counts as a request in its own cycle, so an idle controller
  // services it without first parking it in the pending flag.
  logic wr_req, rd_req, cpu_req, cpu_blocked;
  logic do_jwr, do_jrd, do_crd, do_cwr;

  assign wr_req      = pend_wr | take_action_ocimem_b;
  assign rd_req      = pend_rd | take_no_action_ocimem_a;
  assign cpu_req     = chipselect & (read | write);
  assign cpu_blocked = ~debugaccess & (address >= PROT_ADDR);

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no branch
    // can leave a value unassigned and infer a latch.
    do_jwr = 1'b0;
    do_jrd = 1'b0;
    do_crd = 1'b0;
    do_cwr = 1'b0;
    if (state == IDLE) begin
      if (wr_req)              do_jwr = 1'b1;
      else if (rd_req)         do_jrd = 1'b1;
      else if (cpu_req && read) do_crd = 1'b1;
      else if (cpu_req)        do_cwr = 1'b1;
    end
  end

  logic              ram_en;
  logic              ram_we;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_be    = '1;
    ram_addr  = mon_a_reg;
    ram_wdata = pend_wr ? pend_wr_data : jdo_data;
    if (do_jwr) begin
      ram_en = 1'b1;
      ram_we = 1'b1;
    end else if (do_jrd) begin
      ram_en = 1'b1;
    end else if (do_crd) begin
      ram_en   = 1'b1;
      ram_addr = address;
    end else if (do_cwr) begin
      ram_en    = ~cpu_blocked;
      ram_we    = 1'b1;
      ram_be    = byteenable;
      ram_addr  = address;
      ram_wdata = writedata;
    end
    // The RAM has no reset, so strobes seen while in reset must not reach it.
    if (!reset_n) ram_en = 1'b0;
  end

  nios2_cpu_debug_mon_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      mon_a_reg     <= '0;
      MonDReg       <= '0;
      readdata      <= '0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      pend_wr       <= 1'b0;
      pend_rd       <= 1'b0;
      pend_wr_data  <= '0;
      waitrequest   <= 1'b1;
    end else begin
      // NOTE: state registers use non-blocking assignments so every read in
      // this block sees the pre-edge value regardless of statement order.
      pend_wr <= pend_wr ? ~do_jwr : (take_action_ocimem_b & ~do_jwr);
      pend_rd <= pend_rd ? ~do_jrd : (take_no_action_ocimem_a & ~do_jrd);
      if (take_action_ocimem_b && !pend_wr) pend_wr_data <= jdo_data;

      if (take_action_ocimem_a)
        mon_a_reg <= jdo_addr;
      else if (do_jwr || state == J_CAP)
        mon_a_reg <= mon_a_reg + ADDR_W'(1);

      // Later assignments win: a new event outranks a clear in the same cycle.
      if (take_action_ocimem_a && jdo[JDO_CLR_READY]) monitor_ready <= 1'b0;
      if (state == J_CAP)                             monitor_ready <= 1'b1;
      if (take_action_ocimem_a && jdo[JDO_CLR_ERROR]) monitor_error <= 1'b0;
      if ((take_action_ocimem_b && pend_wr) ||
          (take_no_action_ocimem_a && pend_rd) ||
          (do_cwr && cpu_blocked))                    monitor_error <= 1'b1;

      waitrequest <= 1'b1;
      case (state)
        IDLE: begin
          if (do_jrd) begin
            state <= J_RD;
          end else if (do_crd) begin
            state <= C_RD;
          end else if (do_cwr) begin
            state       <= C_DONE;
            waitrequest <= 1'b0;
          end
        end
        J_RD:  state <= J_CAP;
        J_CAP: begin
          MonDReg <= ram_rdata;
          state   <= IDLE;
        end
        C_RD: begin
          readdata    <= ram_rdata;
          waitrequest <= 1'b0;
          state       <= C_DONE;
        end
        C_DONE:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nios2_cpu_debug_mon_access.md
NIOS2_CPU_DEBUG_MON_ACCESS -- requirements
Module: nios2_cpu_debug_mon_access

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of the monitor RAM; depth is 2**ADDR_W words of 32 bits.
REQ-002 Parameter PROT_BASE, default 8'hF0: first word address of the protected region.
REQ-003 clk  in  1: single clock; all state changes on the rising edge.
REQ-004 reset_n  in  1: reset, asynchronous assert, active-low.
REQ-005 jdo  in  38: JTAG-derived data word, valid in the same cycle as any take_* pulse.
REQ-006 take_action_ocimem_a  in  1: one-cycle pulse; address load and flag-clear command.
REQ-007 take_action_ocimem_b  in  1: one-cycle pulse; JTAG write command.
REQ-008 take_no_action_ocimem_a  in  1: one-cycle pulse; JTAG read command.
REQ-009 address  in  ADDR_W: CPU-side word address.
REQ-010 chipselect, read, write, debugaccess  in  1 each: CPU-side strobes, held until waitrequest is low.
REQ-011 writedata  in  32, byteenable  in  4: CPU write data and lane enables.
REQ-012 readdata  out  32, waitrequest  out  1: CPU read data and stall.
REQ-013 MonDReg  out  32: JTAG read-data register, returned to the debug slave for shifting.
REQ-014 monitor_ready  out  1, monitor_error  out  1: sticky status bits reported to JTAG.

Function
REQ-015 MonAReg (ADDR_W bits) SHALL load jdo[25+ADDR_W:26] on take_action_ocimem_a; jdo[34]=1 SHALL clear monitor_ready and jdo[35]=1 SHALL clear monitor_error in the same cycle.
REQ-016 take_action_ocimem_b SHALL write jdo[34:3] to RAM[MonAReg] with all lanes enabled, then MonAReg SHALL be incremented by 1 with wrap at 2**ADDR_W-1 to 0.
REQ-017 take_no_action_ocimem_a SHALL read RAM[MonAReg]; MonDReg SHALL be updated 2 cycles after the RAM read is issued, monitor_ready SHALL be set in that same cycle, and MonAReg SHALL then increment with wrap.
REQ-018 Each JTAG command type SHALL have a one-deep pending flag; a pulse arriving while the flag for the same type is still set SHALL be dropped and SHALL set monitor_error.
REQ-019 The RAM is single-port; pending JTAG commands SHALL win arbitration over new CPU accesses, and an in-flight CPU access SHALL complete before any JTAG command is issued.
REQ-020 Controller states SHALL be IDLE, J_RD, J_CAP, C_RD, C_DONE: IDLE->J_RD on pending read; IDLE->IDLE on pending write (executed in the same cycle); J_RD->J_CAP->IDLE; IDLE->C_RD on CPU read; C_RD->C_DONE->IDLE; CPU write from IDLE->C_DONE->IDLE.
REQ-021 waitrequest SHALL be high except in C_DONE; a CPU read SHALL return readdata valid in C_DONE, 2 cycles after acceptance; a CPU write SHALL be committed at acceptance with byte-lane masking.
REQ-022 A CPU write to address >= PROT_BASE with debugaccess=0 SHALL be completed without modifying the RAM and SHALL set monitor_error.
REQ-023 When a JTAG write and a CPU access target the same word, the operation that wins arbitration SHALL be observed first by the other, with no merging.
REQ-024 readdata SHALL hold its last value outside C_DONE.

Reset
REQ-025 On reset_n low: state=IDLE, MonAReg=0, MonDReg=0, readdata=0, monitor_ready=0, monitor_error=0, pending flags=0, waitrequest=1; RAM contents are not reset.
REQ-026 Reset asserted mid-operation SHALL abort the operation; no RAM write from a partially executed command SHALL occur after reset_n is deasserted.

Structure
REQ-027 The state encoding, the jdo field positions (address, data, clear bits) and the PROT_BASE default SHALL reside in the shared package nios2_cpu_debug_pkg.
REQ-028 The RAM SHALL be a single sub-module, nios2_cpu_debug_mon_ram: single-port, synchronous read, 1-cycle latency, 4 byte enables, ADDR_W parameter.

Verification
REQ-029 Load address 0x10 via ocimem_a, then issue two ocimem_b writes of 0xDEADBEEF and 0x12345678 -> RAM[0x10]=0xDEADBEEF, RAM[0x11]=0x12345678, MonAReg=0x12.
REQ-030 Load 0x10, then issue no_action_ocimem_a -> MonDReg=0xDEADBEEF and monitor_ready=1 exactly 2 cycles after issue; ocimem_a with jdo[34]=1 -> monitor_ready=0.
REQ-031 MonAReg=0xFF, then JTAG write 0xA5A5A5A5 -> RAM[0xFF] is written and MonAReg=0x00.
REQ-032 CPU write 0xFFFFFFFF, byteenable=4'b0101, to a word holding 0 -> word=0x00FF00FF; waitrequest is low for exactly 1 cycle; a CPU read of the same word returns 0x00FF00FF.
REQ-033 CPU write to 0xF4 with debugaccess=0 -> RAM unchanged, monitor_error=1; the same write with debugaccess=1 -> RAM updated.
REQ-034 JTAG read pulse during C_RD, followed by a second read pulse before the first is serviced -> the CPU read completes first, the first JTAG read completes, the second is dropped, and monitor_error=1.
